// File: rtl/cdr_loop_filter.sv
// Second-order (proportional + integral) bang-bang CDR loop filter driving a wrapping
// phase-interpolator code. Early/late decisions are majority-voted over a fixed window.
module cdr_loop_filter #(
  parameter int unsigned PI_BITS   = 7,
  parameter int unsigned PI_INIT   = 0,
  parameter int unsigned WIN       = 8,
  parameter int unsigned KP        = 1,
  parameter int unsigned KI_SHIFT  = 4,
  parameter int unsigned FREQ_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 dec_valid,
  input  logic [1:0]           decision,
  output logic [PI_BITS-1:0]   pi_code,
  output logic                 pi_update,
  output logic [FREQ_BITS-1:0] freq_acc
);

  localparam int unsigned CW = $clog2(WIN);
  localparam int unsigned VW = CW + 2;
  localparam int unsigned SW = ((PI_BITS > FREQ_BITS) ? PI_BITS : FREQ_BITS) + 2;

  localparam logic signed [SW-1:0]        KP_S = SW'(KP);
  // Symmetric saturation limits, one bit wider than the integrator.
  localparam logic signed [FREQ_BITS:0]   FMAX = {2'b00, {(FREQ_BITS - 1){1'b1}}};
  localparam logic signed [FREQ_BITS:0]   FMIN = {2'b11, {(FREQ_BITS - 2){1'b0}}, 1'b1};

  logic                        accept;
  logic                        close;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [VW-1:0]        vsum_q, vsum_d, vsum_new, vinc;
  logic signed [1:0]           vote;
  logic signed [FREQ_BITS-1:0] freq_q, freq_d, freq_new;
  logic signed [FREQ_BITS:0]   freq_sum;
  logic signed [SW-1:0]        kp_term, freq_ext, step, step_q, step_d;
  logic                        valid_q, valid_d;
  logic [PI_BITS-1:0]          pi_q, pi_d;
  logic                        upd_q, upd_d;
  logic                        unused_step_msbs;

  // Window vote, integrator and step for the decision presented this cycle.
  always_comb begin
    accept = en & dec_valid & ~clr;
    close  = accept && (cnt_q == CW'(WIN - 1));

    vinc = '0;
    if (decision == 2'b01) begin
      vinc = VW'(1);
    end else if (decision == 2'b10) begin
      vinc = '1;
    end
    vsum_new = vsum_q + vinc;

    if (vsum_new[VW-1]) begin
      vote = 2'b11;
    end else if (vsum_new != '0) begin
      vote = 2'b01;
    end else begin
      vote = 2'b00;
    end

    freq_sum = {freq_q[FREQ_BITS-1], freq_q} + {{(FREQ_BITS - 1){vote[1]}}, vote};
    if (freq_sum > FMAX) begin
      freq_new = FMAX[FREQ_BITS-1:0];
    end else if (freq_sum < FMIN) begin
      freq_new = FMIN[FREQ_BITS-1:0];
    end else begin
      freq_new = freq_sum[FREQ_BITS-1:0];
    end

    freq_ext = {{(SW - FREQ_BITS){freq_new[FREQ_BITS-1]}}, freq_new};
    kp_term  = '0;
    if (vote == 2'b01) begin
      kp_term = KP_S;
    end else if (vote == 2'b11) begin
      kp_term = -KP_S;
    end
    step = kp_term + (freq_ext >>> KI_SHIFT);
  end

  always_comb begin
    cnt_d   = cnt_q;
    vsum_d  = vsum_q;
    freq_d  = freq_q;
    step_d  = step_q;
    valid_d = 1'b0;
    pi_d    = pi_q;
    upd_d   = 1'b0;

    // Second pipeline stage; clr cancels an update still in flight.
    if (valid_q && !clr) begin
      pi_d  = pi_q + step_q[PI_BITS-1:0];
      upd_d = 1'b1;
    end

    if (clr) begin
      cnt_d  = '0;
      vsum_d = '0;
      freq_d = '0;
    end else if (accept) begin
      if (close) begin
        cnt_d   = '0;
        vsum_d  = '0;
        freq_d  = freq_new;
        step_d  = step;
        valid_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        vsum_d = vsum_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      vsum_q  <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      pi_q    <= PI_BITS'(PI_INIT);
      upd_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      vsum_q  <= vsum_d;
      freq_q  <= freq_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      pi_q    <= pi_d;
      upd_q   <= upd_d;
    end
  end

  // Only the low PI_BITS of the step matter modulo the code range.
  assign unused_step_msbs = ^step_q[SW-1:PI_BITS];

  assign pi_code   = pi_q;
  assign pi_update = upd_q;
  assign freq_acc  = freq_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Randomized and directed bench for cdr_loop_filter, checked every cycle against an
// integer-arithmetic model of the vote / integrate / step / wrap rules.
module tb_cdr_loop_filter;

  localparam int PI_BITS   = 7;
  localparam int PI_INIT   = 0;
  localparam int WIN       = 8;
  localparam int KP        = 1;
  localparam int KI_SHIFT  = 4;
  localparam int FREQ_BITS = 10;
  localparam int FMAX      = (1 << (FREQ_BITS - 1)) - 1;
  localparam int PI_MOD    = 1 << PI_BITS;

  localparam logic [1:0] LATE  = 2'b01;
  localparam logic [1:0] EARLY = 2'b10;
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] BAD   = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 clr = 1'b0;
  logic                 dec_valid = 1'b0;
  logic [1:0]           decision = 2'b00;
  logic [PI_BITS-1:0]   pi_code;
  logic                 pi_update;
  logic [FREQ_BITS-1:0] freq_acc;

  cdr_loop_filter #(
    .PI_BITS  (PI_BITS),
    .PI_INIT  (PI_INIT),
    .WIN      (WIN),
    .KP       (KP),
    .KI_SHIFT (KI_SHIFT),
    .FREQ_BITS(FREQ_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .dec_valid(dec_valid),
    .decision (decision),
    .pi_code  (pi_code),
    .pi_update(pi_update),
    .freq_acc (freq_acc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_cnt, m_sum, m_freq, m_step, m_pi;
  bit m_pend, m_upd;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_sum  = 0;
    m_freq = 0;
    m_step = 0;
    m_pi   = PI_INIT;
    m_pend = 1'b0;
    m_upd  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":pi_code"}, int'(pi_code), m_pi);
    check({tag, ":pi_update"}, int'(pi_update), int'(m_upd));
    check({tag, ":freq_acc"}, int'($signed(freq_acc)), m_freq);
  endtask

  task automatic cycle(input bit e, input bit c, input bit v, input logic [1:0] d,
                       input string tag);
    int vote;
    en        = e;
    clr       = c;
    dec_valid = v;
    decision  = d;
    @(posedge clk);
    m_upd = m_pend && !c;
    if (m_upd) m_pi = ((m_pi + m_step) % PI_MOD + PI_MOD) % PI_MOD;
    m_pend = 1'b0;
    if (c) begin
      m_cnt  = 0;
      m_sum  = 0;
      m_freq = 0;
    end else if (e && v) begin
      m_cnt++;
      if (d == LATE) m_sum++;
      else if (d == EARLY) m_sum--;
      if (m_cnt == WIN) begin
        vote   = (m_sum > 0) ? 1 : (m_sum < 0) ? -1 : 0;
        m_freq = m_freq + vote;
        if (m_freq > FMAX) m_freq = FMAX;
        if (m_freq < -FMAX) m_freq = -FMAX;
        m_step = vote * KP + (m_freq >>> KI_SHIFT);
        m_pend = 1'b1;
        m_cnt  = 0;
        m_sum  = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, NONE, "idle");
  endtask

  task automatic window(input logic [1:0] d, input string tag);
    for (int i = 0; i < WIN; i++) cycle(1'b1, 1'b0, 1'b1, d, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    #10 rst_n = 1'b1;

    // Reset mid-window, then one proportional step with dec_valid gaps
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, LATE, "pre_rst");
    async_reset("mid_rst");
    for (int i = 0; i < WIN; i++) begin
      cycle(1'b1, 1'b0, 1'b1, LATE, "prop");
      cycle(1'b1, 1'b0, 1'b0, LATE, "prop_gap");
    end
    idle(3);
    check("prop_pi_final", int'(pi_code), 1);
    check("prop_freq_final", int'($signed(freq_acc)), 1);

    // Downward wrap, then upward wrap through zero
    async_reset("wrap_rst");
    window(EARLY, "early");
    idle(3);
    check("wrap_down_pi", int'(pi_code), 126);
    check("wrap_down_freq", int'($signed(freq_acc)), -1);
    window(LATE, "late_a");
    idle(2);
    window(LATE, "late_b");
    idle(2);
    check("wrap_up_pi", int'(pi_code), 0);

    // Tie window and invalid-only window
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, EARLY, "tie_e");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, LATE, "tie_l");
    window(BAD, "null");
    idle(3);

    // clr on the closing decision, then clr one cycle after a close
    for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 1'b0, 1'b1, LATE, "clr_pre");
    cycle(1'b1, 1'b1, 1'b1, LATE, "clr_close");
    idle(3);
    check("clr_freq", int'($signed(freq_acc)), 0);
    window(LATE, "inflight");
    cycle(1'b1, 1'b1, 1'b0, NONE, "clr_inflight");
    idle(2);

    // en low mid-window consumes no slots
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, LATE, "en_a");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, LATE, "en_off");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, LATE, "en_b");
    idle(3);

    // Random traffic with occasional clr and enable drops
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [1:0]  d;
      r = $urandom_range(0, 9);
      d = (r < 5) ? LATE : (r < 7) ? EARLY : (r < 9) ? NONE : BAD;
      if (i >= 1500) d = (r < 3) ? LATE : (r < 8) ? EARLY : d;
      cycle(($urandom % 8) != 0, ($urandom % 60) == 0, ($urandom % 4) != 0, d, "rand");
    end

    // Integral path from reset, continuing into saturation
    async_reset("int_rst");
    for (int w = 0; w < 16; w++) window(LATE, "integ");
    idle(2);
    check("integ_freq", int'($signed(freq_acc)), 16);
    check("integ_pi", int'(pi_code), 17);
    for (int w = 0; w < FMAX + 10; w++) window(LATE, "sat");
    idle(2);
    check("sat_freq", int'($signed(freq_acc)), FMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
